// File: rtl/dti_pack.sv
// Shared widths and types for the DTI page-request path.
package dti_pack;

  localparam int unsigned CUSTOM_DATA_WIDTH = 32;
  localparam int unsigned CUSTOM_KEEP_WIDTH = 4;
  localparam int unsigned TBU_NUM_WIDTH     = 4;

  // One REQ flit as carried on req_payload: data in the upper bits, keep in the lower.
  typedef struct packed {
    logic [CUSTOM_DATA_WIDTH-1:0] data;
    logic [CUSTOM_KEEP_WIDTH-1:0] keep;
  } dti_flit_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DROP,
    OUT
  } dti_depack_state_e;

endpackage

// File: rtl/dti_pr_req_depack.sv
// Rebuilds one multi-beat DTI message from the REQ flit stream and hands it
// to the protocol decoder; flags and counts malformed packets.
module dti_pr_req_depack
  import dti_pack::*;
#(
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     req_valid,
  input  logic [CUSTOM_DATA_WIDTH+CUSTOM_KEEP_WIDTH-1:0] req_payload,
  input  logic                                     req_last,
  input  logic [TBU_NUM_WIDTH-1:0]                 req_srcid,
  input  logic [TBU_NUM_WIDTH-1:0]                 req_tgtid,
  input  logic                                     req_qos,
  output logic                                     req_threshold,
  output logic                                     req_ready,
  output logic                                     msg_valid,
  output logic [MAX_BEATS*CUSTOM_DATA_WIDTH-1:0]   msg_data,
  output logic [MAX_BEATS*CUSTOM_KEEP_WIDTH-1:0]   msg_keep,
  output logic [$clog2(MAX_BEATS+1)-1:0]           msg_beats,
  output logic [TBU_NUM_WIDTH-1:0]                 msg_srcid,
  output logic [TBU_NUM_WIDTH-1:0]                 msg_tgtid,
  output logic                                     msg_err,
  input  logic                                     msg_ready,
  output logic [ERR_CNT_W-1:0]                     err_cnt
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  dti_depack_state_e          r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [TBU_NUM_WIDTH-1:0]   r_srcid;
  logic [TBU_NUM_WIDTH-1:0]   r_tgtid;
  logic                       r_err;
  logic [ERR_CNT_W-1:0]       r_err_cnt;
  logic                       r_msg_valid;
  logic                       r_req_ready;

  dti_flit_t                  w_flit;
  logic                       w_take;
  logic                       w_first;
  logic                       w_acc;
  logic                       w_id_diff;
  logic                       w_unused;

  assign w_flit    = req_payload;
  assign w_take    = req_valid && r_req_ready;
  assign w_first   = w_take && (r_state == IDLE);
  assign w_acc     = w_take && (r_state == ACCUM);
  assign w_id_diff = (req_srcid != r_srcid) || (req_tgtid != r_tgtid);
  assign w_unused  = req_qos;

  // Control FSM; req_ready/msg_valid are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_srcid     <= '0;
      r_tgtid     <= '0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_msg_valid <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_cnt   <= CNT_W'(1);
            r_srcid <= req_srcid;
            r_tgtid <= req_tgtid;
            r_err   <= 1'b0;
            if (req_last) begin
              r_state     <= OUT;
              r_msg_valid <= 1'b1;
              r_req_ready <= 1'b0;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_take) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_id_diff) begin
              r_err <= 1'b1;
            end
            if (req_last) begin
              r_state     <= OUT;
              r_msg_valid <= 1'b1;
              r_req_ready <= 1'b0;
            end else if (r_cnt + CNT_W'(1) == CNT_W'(MAX_BEATS)) begin
              // Buffer full without last: the rest of the packet is discarded.
              r_err   <= 1'b1;
              r_state <= DROP;
            end
          end
        end
        DROP: begin
          if (w_take && req_last) begin
            r_state     <= OUT;
            r_msg_valid <= 1'b1;
            r_req_ready <= 1'b0;
          end
        end
        OUT: begin
          if (msg_ready) begin
            r_state     <= IDLE;
            r_msg_valid <= 1'b0;
            r_req_ready <= 1'b1;
            if (r_err && (r_err_cnt != '1)) begin
              r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_msg_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Message buffer: one slot per beat, first flit of a message wipes the rest.
  for (genvar g = 0; g < MAX_BEATS; g++) begin : g_slot
    logic [CUSTOM_DATA_WIDTH-1:0] r_data;
    logic [CUSTOM_KEEP_WIDTH-1:0] r_keep;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data <= '0;
        r_keep <= '0;
      end else if (w_first) begin
        r_data <= (g == 0) ? w_flit.data : '0;
        r_keep <= (g == 0) ? w_flit.keep : '0;
      end else if (w_acc && (r_cnt == CNT_W'(g))) begin
        r_data <= w_flit.data;
        r_keep <= w_flit.keep;
      end
    end

    assign msg_data[g*CUSTOM_DATA_WIDTH +: CUSTOM_DATA_WIDTH] = r_data;
    assign msg_keep[g*CUSTOM_KEEP_WIDTH +: CUSTOM_KEEP_WIDTH] = r_keep;
  end

  assign req_threshold = 1'b1;
  assign req_ready     = r_req_ready;
  assign msg_valid     = r_msg_valid;
  assign msg_beats     = r_cnt;
  assign msg_srcid     = r_srcid;
  assign msg_tgtid     = r_tgtid;
  assign msg_err       = r_err;
  assign err_cnt       = r_err_cnt;

endmodule
